// File: rtl/pgm_sound_mailbox.sv
// 68k <-> Z80 sound mailbox: per-channel command/reply latches with NMI pulse generator.
// Define PGM_MBOX_FIFO_EN to turn the channel-0 command latch into a FIFO_DEPTH-entry FIFO.
module pgm_sound_mailbox #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NMI_LEN    = 4,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              fixed_20m_clk,
    input  logic              reset_n,
    input  logic              m_wr,
    input  logic              m_rd,
    input  logic [CH_W-1:0]   m_ch,
    input  logic [DATA_W-1:0] m_din,
    output logic [DATA_W-1:0] m_dout,
    output logic [NUM_CH-1:0] m_status,
    output logic [NUM_CH-1:0] m_ovf,
    input  logic              m_ovf_clr,
    input  logic              z_wr,
    input  logic              z_rd,
    input  logic [CH_W-1:0]   z_ch,
    input  logic [DATA_W-1:0] z_din,
    output logic [DATA_W-1:0] z_dout,
    output logic [NUM_CH-1:0] z_status,
    output logic              z_nmi_n
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} nmi_state_e;

    logic [DATA_W-1:0] cmd_q [NUM_CH];
    logic [DATA_W-1:0] cmd_d [NUM_CH];
    logic [DATA_W-1:0] rep_q [NUM_CH];
    logic [DATA_W-1:0] rep_d [NUM_CH];
    logic [NUM_CH-1:0] z_status_q, z_status_d;
    logic [NUM_CH-1:0] m_status_q, m_status_d;
    logic [NUM_CH-1:0] m_ovf_q, m_ovf_d, ovf_base;
    logic [DATA_W-1:0] m_dout_q, m_dout_d;
    logic [DATA_W-1:0] z_dout_q, z_dout_d;

    logic              m_ch_ok;
    logic              z_ch_ok;
    logic [DATA_W-1:0] cmd_sel;
    logic [DATA_W-1:0] rep_sel;
    logic              m_wr_acc;

    nmi_state_e        state_q, state_d;
    logic [3:0]        nmi_cnt_q, nmi_cnt_d;
    logic              nmi_pend_q, nmi_pend_d;

    // Out-of-range channels read back as all ones.
    always_comb begin
        m_ch_ok = 32'(m_ch) < NUM_CH;
        z_ch_ok = 32'(z_ch) < NUM_CH;
        cmd_sel = '1;
        rep_sel = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(z_ch) == i) cmd_sel = cmd_q[i];
            if (32'(m_ch) == i) rep_sel = rep_q[i];
        end
    end

`ifdef PGM_MBOX_FIFO_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    always_comb begin
        fifo_full  = fifo_cnt_q == CNT_W'(FIFO_DEPTH);
        fifo_empty = fifo_cnt_q == '0;
        fifo_pop   = z_rd && (z_ch == '0) && !fifo_empty;
        fifo_push  = m_wr && (m_ch == '0) && (!fifo_full || fifo_pop);
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                fifo_q[wr_ptr_q] <= m_din;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end
`endif

    always_comb begin
        m_wr_acc = m_wr && m_ch_ok;
`ifdef PGM_MBOX_FIFO_EN
        if (m_ch == '0) m_wr_acc = fifo_push;
`endif
    end

    // Latch next state: reads take the old contents, a same-cycle write leaves the flag set.
    always_comb begin
        cmd_d      = cmd_q;
        rep_d      = rep_q;
        z_status_d = z_status_q;
        m_status_d = m_status_q;
        ovf_base   = m_ovf_clr ? '0 : m_ovf_q;
        m_ovf_d    = ovf_base;
        m_dout_d   = m_dout_q;
        z_dout_d   = z_dout_q;

        if (z_rd) z_dout_d = cmd_sel;
        if (m_rd) m_dout_d = rep_sel;

        for (int i = 0; i < NUM_CH; i++) begin
            if (z_rd && z_ch_ok && 32'(z_ch) == i) z_status_d[i] = 1'b0;
            if (m_rd && m_ch_ok && 32'(m_ch) == i) m_status_d[i] = 1'b0;
            if (m_wr && m_ch_ok && 32'(m_ch) == i) begin
                cmd_d[i]      = m_din;
                z_status_d[i] = 1'b1;
                if (z_status_q[i]) m_ovf_d[i] = 1'b1;
            end
            if (z_wr && z_ch_ok && 32'(z_ch) == i) begin
                rep_d[i]      = z_din;
                m_status_d[i] = 1'b1;
            end
        end

`ifdef PGM_MBOX_FIFO_EN
        cmd_d[0]      = '0;
        z_status_d[0] = 1'b0;
        m_ovf_d[0]    = ovf_base[0] | (m_wr && (m_ch == '0) && fifo_full && !fifo_pop);
        if (z_rd && (z_ch == '0)) z_dout_d = fifo_pop ? fifo_q[rd_ptr_q] : z_dout_q;
`endif
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cmd_q[i] <= '0;
                rep_q[i] <= '0;
            end
            z_status_q <= '0;
            m_status_q <= '0;
            m_ovf_q    <= '0;
            m_dout_q   <= '0;
            z_dout_q   <= '0;
        end else begin
            cmd_q      <= cmd_d;
            rep_q      <= rep_d;
            z_status_q <= z_status_d;
            m_status_q <= m_status_d;
            m_ovf_q    <= m_ovf_d;
            m_dout_q   <= m_dout_d;
            z_dout_q   <= z_dout_d;
        end
    end

    // NMI state register
    always_ff @(posedge fixed_20m_clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            nmi_cnt_q  <= '0;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nmi_cnt_q  <= nmi_cnt_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // NMI next state; writes during PULSE/GAP coalesce into one follow-up pulse.
    always_comb begin
        state_d    = state_q;
        nmi_cnt_d  = nmi_cnt_q;
        nmi_pend_d = nmi_pend_q;
        unique case (state_q)
            StIdle: begin
                if (m_wr_acc) begin
                    state_d   = StPulse;
                    nmi_cnt_d = '0;
                end
            end
            StPulse: begin
                if (m_wr_acc) nmi_pend_d = 1'b1;
                if (nmi_cnt_q == 4'(NMI_LEN - 1)) begin
                    state_d   = StGap;
                    nmi_cnt_d = '0;
                end else begin
                    nmi_cnt_d = nmi_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (m_wr_acc) nmi_pend_d = 1'b1;
                if (nmi_cnt_q == 4'd1) begin
                    nmi_cnt_d = '0;
                    if (nmi_pend_q || m_wr_acc) begin
                        state_d    = StPulse;
                        nmi_pend_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    nmi_cnt_d = nmi_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                nmi_cnt_d  = '0;
                nmi_pend_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        z_nmi_n  = (state_q != StPulse);
        z_status = z_status_q;
`ifdef PGM_MBOX_FIFO_EN
        z_status[0] = !fifo_empty;
`endif
        m_status = m_status_q;
        m_ovf    = m_ovf_q;
        m_dout   = m_dout_q;
        z_dout   = z_dout_q;
    end

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Randomized bench for pgm_sound_mailbox against a timeline/queue reference model.
module tb_pgm_sound_mailbox;

    localparam int NCH   = 3;
    localparam int NLEN  = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       m_wr, m_rd, m_ovf_clr, z_wr, z_rd;
    logic [1:0] m_ch, z_ch;
    logic [7:0] m_din, z_din, m_dout, z_dout;
    logic [2:0] m_status, m_ovf, z_status;
    logic       z_nmi_n;

    pgm_sound_mailbox #(
        .NUM_CH    (NCH),
        .DATA_W    (8),
        .FIFO_DEPTH(DEPTH),
        .NMI_LEN   (NLEN)
    ) dut (
        .fixed_20m_clk(clk),
        .reset_n      (rst_n),
        .m_wr         (m_wr),
        .m_rd         (m_rd),
        .m_ch         (m_ch),
        .m_din        (m_din),
        .m_dout       (m_dout),
        .m_status     (m_status),
        .m_ovf        (m_ovf),
        .m_ovf_clr    (m_ovf_clr),
        .z_wr         (z_wr),
        .z_rd         (z_rd),
        .z_ch         (z_ch),
        .z_din        (z_din),
        .z_dout       (z_dout),
        .z_status     (z_status),
        .z_nmi_n      (z_nmi_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    logic [7:0] md_cmd [NCH];
    logic [7:0] md_rep [NCH];
    logic [2:0] md_zst, md_mst, md_ovf;
    logic [7:0] md_mdout, md_zdout;
    logic [7:0] md_fifo [$];
    int         cyc;
    bit         nmi_act, nmi_pend;
    int         nmi_start;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit         acc;
        logic [2:0] zst_old;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                md_cmd[i] = '0;
                md_rep[i] = '0;
            end
            md_zst = '0; md_mst = '0; md_ovf = '0;
            md_mdout = '0; md_zdout = '0;
            nmi_act = 0; nmi_pend = 0;
            md_fifo.delete();
            return;
        end
        acc     = 0;
        zst_old = md_zst;
        if (m_ovf_clr) md_ovf = '0;
        // Reply path
        if (m_rd) begin
            if (m_ch < NCH) begin
                md_mdout     = md_rep[m_ch];
                md_mst[m_ch] = 1'b0;
            end else begin
                md_mdout = 8'hFF;
            end
        end
        if (z_wr && z_ch < NCH) begin
            md_rep[z_ch] = z_din;
            md_mst[z_ch] = 1'b1;
        end
        // Command path
        if (z_rd) begin
            if (z_ch >= NCH) md_zdout = 8'hFF;
`ifdef PGM_MBOX_FIFO_EN
            else if (z_ch == 0) begin
                if (md_fifo.size() > 0) md_zdout = md_fifo.pop_front();
            end
`endif
            else begin
                md_zdout     = md_cmd[z_ch];
                md_zst[z_ch] = 1'b0;
            end
        end
        if (m_wr && m_ch < NCH) begin
`ifdef PGM_MBOX_FIFO_EN
            if (m_ch == 0) begin
                if (md_fifo.size() < DEPTH) begin
                    md_fifo.push_back(m_din);
                    acc = 1;
                end else begin
                    md_ovf[0] = 1'b1;
                end
            end else
`endif
            begin
                if (zst_old[m_ch]) md_ovf[m_ch] = 1'b1;
                md_cmd[m_ch] = m_din;
                md_zst[m_ch] = 1'b1;
                acc = 1;
            end
        end
        // NMI timeline: pulse covers cycles [start, start+NLEN), gap of 2, then re-pulse if pending.
        if (nmi_act && cyc <= nmi_start + NLEN + 2) begin
            if (acc && cyc > nmi_start) nmi_pend = 1;
            if (cyc == nmi_start + NLEN + 2) begin
                if (nmi_pend) begin
                    nmi_start = cyc;
                    nmi_pend  = 0;
                end else begin
                    nmi_act = 0;
                end
            end
        end else if (acc) begin
            nmi_act   = 1;
            nmi_start = cyc;
        end
    endtask

    task automatic compare_all();
        logic [2:0] exp_zst;
        logic       exp_nmi;
        exp_zst = md_zst;
`ifdef PGM_MBOX_FIFO_EN
        exp_zst[0] = md_fifo.size() != 0;
`endif
        exp_nmi = !(nmi_act && cyc >= nmi_start && cyc < nmi_start + NLEN);
        check_eq("m_dout", m_dout, md_mdout);
        check_eq("z_dout", z_dout, md_zdout);
        check_eq("m_status", m_status, md_mst);
        check_eq("z_status", z_status, exp_zst);
        check_eq("m_ovf", m_ovf, md_ovf);
        check_eq("z_nmi_n", z_nmi_n, exp_nmi);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        m_wr = 0; m_rd = 0; z_wr = 0; z_rd = 0; m_ovf_clr = 0;
    endtask

    int          lowcnt;
    logic [15:0] pat;

    initial begin
        cyc = 0; nmi_act = 0; nmi_pend = 0; nmi_start = 0;
        idle_inputs();
        m_ch = 0; z_ch = 0; m_din = 0; z_din = 0;
        rst_n = 0;
        tick();
        tick();
        check_eq("rst_nmi", z_nmi_n, 1);
        check_eq("rst_zst", z_status, 0);
        check_eq("rst_zdout", z_dout, 0);
        rst_n = 1;
        tick();

        // Same-cycle reply write and read
        z_wr = 1; z_ch = 0; z_din = 8'h33; m_rd = 1; m_ch = 0;
        tick(); idle_inputs();
        check_eq("wr_rd_old", m_dout, 8'h00);
        check_eq("wr_rd_pend", m_status[0], 1);
        m_rd = 1; m_ch = 0;
        tick(); idle_inputs();
        check_eq("rd_new", m_dout, 8'h33);
        check_eq("rd_clear", m_status[0], 0);

        // Command write/read with NMI pulse
        m_wr = 1; m_ch = 1; m_din = 8'h5A;
        tick(); idle_inputs();
        check_eq("cmd_pend", z_status[1], 1);
        check_eq("nmi_start", z_nmi_n, 0);
        lowcnt = 1;
        z_rd = 1; z_ch = 1;
        tick(); idle_inputs();
        check_eq("cmd_read", z_dout, 8'h5A);
        check_eq("cmd_clear", z_status[1], 0);
        lowcnt += !z_nmi_n;
        for (int i = 0; i < 5; i++) begin
            tick();
            lowcnt += !z_nmi_n;
        end
        check_eq("nmi_len", lowcnt, NLEN);

        // Overflow and clear
        m_wr = 1; m_ch = 2; m_din = 8'h11; tick();
        m_din = 8'h22; tick(); idle_inputs();
        check_eq("ovf_set", m_ovf[2], 1);
        z_rd = 1; z_ch = 2; tick(); idle_inputs();
        check_eq("ovf_data", z_dout, 8'h22);
        m_ovf_clr = 1; tick(); idle_inputs();
        check_eq("ovf_clr", m_ovf, 0);
        repeat (10) tick();

        // Three writes in one pulse -> two pulses, 2 high cycles apart
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 3) begin
                m_wr = 1; m_ch = 1; m_din = 8'(i);
            end
            tick(); idle_inputs();
            pat[i] = z_nmi_n;
        end
        check_eq("nmi_coalesce", pat, 16'hFC30);
        m_ovf_clr = 1; tick(); idle_inputs();

`ifdef PGM_MBOX_FIFO_EN
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 1; i <= 5; i++) begin
            m_wr = 1; m_ch = 0; m_din = 8'(i);
            tick();
        end
        idle_inputs();
        check_eq("fifo_ovf", m_ovf[0], 1);
        for (int i = 1; i <= 5; i++) begin
            z_rd = 1; z_ch = 0;
            tick();
            check_eq("fifo_rd", z_dout, (i == 5) ? 4 : i);
        end
        idle_inputs();
`endif

        // Reset mid-pulse, then out-of-range channel
        repeat (12) tick();
        m_wr = 1; m_ch = 1; m_din = 8'h77; tick();
        check_eq("pulse_on", z_nmi_n, 0);
        rst_n = 0; m_ch = 2; tick();
        rst_n = 1; idle_inputs();
        check_eq("rst_pulse_nmi", z_nmi_n, 1);
        check_eq("rst_pulse_zst", z_status, 0);
        check_eq("rst_pulse_ovf", m_ovf, 0);
        m_wr = 1; m_ch = 3; m_din = 8'h55; tick(); idle_inputs();
        check_eq("oor_zst", z_status, 0);
        check_eq("oor_nmi", z_nmi_n, 1);
        z_rd = 1; z_ch = 3; tick(); idle_inputs();
        check_eq("oor_read", z_dout, 8'hFF);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            m_wr      = ($urandom_range(0, 2) == 0);
            m_rd      = ($urandom_range(0, 2) == 0);
            z_wr      = ($urandom_range(0, 2) == 0);
            z_rd      = ($urandom_range(0, 2) == 0);
            m_ovf_clr = ($urandom_range(0, 19) == 0);
            m_ch      = 2'($urandom_range(0, 3));
            z_ch      = 2'($urandom_range(0, 3));
            m_din     = 8'($urandom);
            z_din     = 8'($urandom);
            tick();
        end
        idle_inputs();
        rst_n = 1;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
